mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 33 +++
 rtl/mul_div_unit_div_step.sv | 19 +
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 tb/tb_mul_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings,
// iteration count default, FSM state codes and small helpers.
package mul_div_unit_pkg;

  localparam int MDU_OP_LENGTH  = 3;
  localparam int MDU_CYCLES_DEF = 32;

  typedef logic [MDU_OP_LENGTH-1:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 3'b000;
  localparam mdu_op_t MDU_MULT  = 3'b001;
  localparam mdu_op_t MDU_MULTU = 3'b010;
  localparam mdu_op_t MDU_DIV   = 3'b011;
  localparam mdu_op_t MDU_DIVU  = 3'b100;
  localparam mdu_op_t MDU_MTHI  = 3'b101;
  localparam mdu_op_t MDU_MTLO  = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Operations that occupy the iterative datapath and stall the pipeline.
  function automatic logic is_long_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Magnitude of a 32-bit value; only negates when treated as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module mdu_div_step (
  input  logic [31:0] i_rem,
  input  logic        i_bit,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic        o_q
);

  logic [32:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  // Compare at 33 bits so a zero divisor still yields all-ones quotient and
  // lets the dividend bits accumulate unchanged in the remainder.
  assign o_q     = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q ? (w_shift[31:0] - i_divisor) : w_shift[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for a request; MTHI/MTLO write HI/LO directly
//   CALC  | one shift-add or restoring-subtract step per clock
//   FIX   | apply sign correction and commit HI/LO
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MDU_OP_LENGTH-1:0] mdu_op,
  input  logic [31:0]              opnd1,
  input  logic [31:0]              opnd2,
  input  logic                     flush,
  output logic                     busy,
  output logic                     stall,
  output logic                     done,
  output logic [31:0]              hi,
  output logic [31:0]              lo
);

  localparam int CW = $clog2(MDU_CYCLES + 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_ph;      // product high / partial remainder
  logic [31:0]   r_pl;      // multiplier+product low / dividend+quotient
  logic [31:0]   r_opnd2;   // multiplicand or divisor magnitude
  logic          r_is_div;
  logic          r_neg_lo;  // negate product or quotient
  logic          r_neg_hi;  // negate remainder
  logic          r_div0;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_done;

  logic          w_signed;
  logic [32:0]   w_mul_sum;
  logic [31:0]   w_div_rem;
  logic          w_div_q;
  logic [63:0]   w_prod;
  logic [63:0]   w_prod_res;
  logic [31:0]   w_q_res;
  logic [31:0]   w_r_res;

  assign w_signed  = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
  assign w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opnd2} : 33'd0);

  mdu_div_step u_div_step (
    .i_rem     (r_ph),
    .i_bit     (r_pl[31]),
    .i_divisor (r_opnd2),
    .o_rem     (w_div_rem),
    .o_q       (w_div_q)
  );

  assign w_prod     = {r_ph, r_pl};
  assign w_prod_res = r_neg_lo ? (64'd0 - w_prod) : w_prod;
  assign w_q_res    = r_neg_lo ? (32'd0 - r_pl) : r_pl;
  assign w_r_res    = r_neg_hi ? (32'd0 - r_ph) : r_ph;

  // Sequencer and datapath: latch, iterate, correct and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ph     <= '0;
      r_pl     <= '0;
      r_opnd2  <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (is_long_op(mdu_op)) begin
              r_is_div <= (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
              r_div0   <= (opnd2 == 32'd0);
              r_ph     <= '0;
              r_cnt    <= '0;
              r_state  <= S_CALC;
              if ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) begin
                // Multiplier shifts out of r_pl while the product shifts in.
                r_pl     <= abs32(opnd2, w_signed);
                r_opnd2  <= abs32(opnd1, w_signed);
                r_neg_lo <= w_signed && (opnd1[31] ^ opnd2[31]);
                r_neg_hi <= 1'b0;
              end else begin
                r_pl     <= abs32(opnd1, w_signed);
                r_opnd2  <= abs32(opnd2, w_signed);
                // A zero divisor keeps the raw all-ones quotient.
                r_neg_lo <= w_signed && (opnd1[31] ^ opnd2[31]) && (opnd2 != 32'd0);
                r_neg_hi <= w_signed && opnd1[31];
              end
            end else if (mdu_op == MDU_MTHI) begin
              r_hi <= opnd1;
            end else if (mdu_op == MDU_MTLO) begin
              r_lo <= opnd1;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_ph <= w_div_rem;
              r_pl <= {r_pl[30:0], w_div_q};
            end else begin
              r_ph <= w_mul_sum[32:1];
              r_pl <= {w_mul_sum[0], r_pl[31:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(MDU_CYCLES - 1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            if (r_is_div) begin
              r_hi <= w_r_res;
              r_lo <= w_q_res;
            end else begin
              r_hi <= w_prod_res[63:32];
              r_lo <= w_prod_res[31:0];
            end
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign stall = busy || (start && is_long_op(mdu_op));
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO are queued at issue and
// checked by an independent monitor on every done pulse.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] opnd1;
  logic [31:0] opnd2;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mul_div_unit #(.MDU_CYCLES(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mdu_op (mdu_op),
    .opnd1  (opnd1),
    .opnd2  (opnd2),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    opnd1  = a;
    opnd2  = b;
  endtask

  task automatic idle_inputs();
    start  = 1'b0;
    mdu_op = MDU_NONE;
    opnd1  = '0;
    opnd2  = '0;
  endtask

  // Issue a long op, expect result via scoreboard, check busy length.
  // A nonzero inject_at starts a DIVU at that busy cycle, which must be ignored.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inject_at);
    int cnt;
    exp_t e;
    @(negedge clk);
    issue(op, a, b);
    e.name = name; e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    #1 check({name, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    idle_inputs();
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (inject_at != 0 && cnt == inject_at) begin
        issue(MDU_DIVU, 32'd100, 32'd7);
        #1 check({name, "_stall_busy"}, {31'd0, stall}, 32'd1);
      end
      @(negedge clk);
      idle_inputs();
    end
    check({name, "_busy_cycles"}, cnt, 32'd33);
    @(negedge clk);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    flush = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    run_op("mult_neg3x7",   MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("divu_100_7",    MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        0);
    run_op("div_neg7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_5_0",      MDU_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 0);
    run_op("div_min_m1",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 0);
    run_op("div_min_0",     MDU_DIV,   32'h8000_0000, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("multu_max",     MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_min_min",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        0);
    run_op("div_13_neg4",   MDU_DIV,   32'd13,        32'hFFFF_FFFC, 32'd1,        32'hFFFF_FFFD, 0);

    // MTHI/MTLO write directly and never stall.
    @(negedge clk);
    issue(MDU_MTHI, 32'h1234, 32'd0);
    #1 check("mthi_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    @(negedge clk);
    idle_inputs();
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    // DIVU issued mid-MULTU is ignored.
    run_op("multu_2x3_ign", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 5);
    check("ign_busy_after", {31'd0, busy}, 32'd0);

    // Flush in IDLE suppresses start.
    @(negedge clk);
    issue(MDU_MTHI, 32'h55, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    issue(MDU_MULTU, 32'd4, 32'd4);
    @(negedge clk);
    idle_inputs();
    flush = 1'b0;
    check("idle_flush_hi", hi, 32'd0);
    check("idle_flush_busy", {31'd0, busy}, 32'd0);

    // Flush at the 10th CALC cycle: HI/LO preserved, no done.
    issue(MDU_MTHI, 32'hA, 32'd0);
    @(negedge clk);
    issue(MDU_MTLO, 32'hB, 32'd0);
    @(negedge clk);
    issue(MDU_MULTU, 32'd5, 32'd6);
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'hA);
    check("flush_lo", lo, 32'hB);
    repeat (40) @(negedge clk);
    check("flush_hi_later", hi, 32'hA);

    // Reset while in FIX.
    issue(MDU_MULTU, 32'd9, 32'd9);
    @(negedge clk);
    idle_inputs();
    repeat (32) @(negedge clk);
    check("fix_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("fixrst_busy", {31'd0, busy}, 32'd0);
    check("fixrst_hi", hi, 32'd0);
    check("fixrst_lo", lo, 32'd0);
    check("fixrst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
